// File: rtl/phy_reset_seq.sv
// Multi-channel PHY reset sequencer: each channel holds its active-low reset,
// releases it (staggered after power-on), waits a settle time, then flags ready.
module phy_reset_seq #(
  parameter int CH          = 2,
  parameter int CNT_W       = 20,
  parameter int ASSERT_CYC  = 3,
  parameter int STAGGER_CYC = 0,
  parameter int WAIT_CYC    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] req,
  output logic [CH-1:0] phy_rst_n,
  output logic [CH-1:0] ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_SETTLE,
    S_READY
  } state_t;

  localparam logic [CNT_W-1:0] REQ_LEN   = CNT_W'(ASSERT_CYC);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      // Stagger applies only to the power-on hold; re-requests use the plain hold.
      localparam logic [CNT_W-1:0] POR_LEN = CNT_W'(ASSERT_CYC + gi * STAGGER_CYC);

      state_t           state_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] hold_len_reg;
      logic             phy_rst_n_reg;
      logic             ready_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg     <= S_HOLD;
          cnt_reg       <= '0;
          hold_len_reg  <= POR_LEN;
          phy_rst_n_reg <= 1'b0;
          ready_reg     <= 1'b0;
        end else if (req[gi]) begin
          state_reg     <= S_HOLD;
          cnt_reg       <= '0;
          hold_len_reg  <= REQ_LEN;
          phy_rst_n_reg <= 1'b0;
          ready_reg     <= 1'b0;
        end else begin
          case (state_reg)
            S_HOLD: begin
              if (cnt_reg == hold_len_reg - CNT_ONE) begin
                cnt_reg       <= '0;
                phy_rst_n_reg <= 1'b1;
                if (WAIT_CYC == 0) begin
                  state_reg <= S_READY;
                  ready_reg <= 1'b1;
                end else begin
                  state_reg <= S_SETTLE;
                  ready_reg <= 1'b0;
                end
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end
            S_SETTLE: begin
              if (cnt_reg == WAIT_LAST) begin
                state_reg <= S_READY;
                cnt_reg   <= '0;
                ready_reg <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end
            S_READY: begin
              cnt_reg <= '0;
            end
            default: begin
              state_reg     <= S_HOLD;
              cnt_reg       <= '0;
              phy_rst_n_reg <= 1'b0;
              ready_reg     <= 1'b0;
            end
          endcase
        end
      end

      assign phy_rst_n[gi] = phy_rst_n_reg;
      assign ready[gi]     = ready_reg;
    end
  endgenerate

  assign busy = ~&ready;

endmodule

// File: tb/tb_phy_reset_seq.sv
// Bench for phy_reset_seq: two configurations checked every edge against a
// timeline model (release edge = last hold start + hold length).
module tb_phy_reset_seq;

  localparam int A_CH = 2, A_ASSERT = 4, A_STAG = 3, A_WAIT = 5;
  localparam int B_CH = 3, B_ASSERT = 1, B_STAG = 0, B_WAIT = 0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [A_CH-1:0] req_a = '0;
  logic [B_CH-1:0] req_b = '0;
  logic [A_CH-1:0] phy_a, rdy_a;
  logic [B_CH-1:0] phy_b, rdy_b;
  logic            busy_a, busy_b;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int a_start[A_CH], a_len[A_CH];
  int b_start[B_CH], b_len[B_CH];

  always #5 clk = ~clk;

  phy_reset_seq #(.CH(A_CH), .CNT_W(20), .ASSERT_CYC(A_ASSERT), .STAGGER_CYC(A_STAG), .WAIT_CYC(A_WAIT)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .phy_rst_n(phy_a), .ready(rdy_a), .busy(busy_a));

  phy_reset_seq #(.CH(B_CH), .CNT_W(20), .ASSERT_CYC(B_ASSERT), .STAGGER_CYC(B_STAG), .WAIT_CYC(B_WAIT)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .phy_rst_n(phy_b), .ready(rdy_b), .busy(busy_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_reset();
    edge_n = 0;
    for (int i = 0; i < A_CH; i++) begin a_start[i] = 0; a_len[i] = A_ASSERT + i * A_STAG; end
    for (int i = 0; i < B_CH; i++) begin b_start[i] = 0; b_len[i] = B_ASSERT + i * B_STAG; end
  endtask

  task automatic check_model();
    logic [A_CH-1:0] ep_a, er_a;
    logic [B_CH-1:0] ep_b, er_b;
    for (int i = 0; i < A_CH; i++) begin
      ep_a[i] = (edge_n >= a_start[i] + a_len[i]);
      er_a[i] = (edge_n >= a_start[i] + a_len[i] + A_WAIT);
    end
    for (int i = 0; i < B_CH; i++) begin
      ep_b[i] = (edge_n >= b_start[i] + b_len[i]);
      er_b[i] = (edge_n >= b_start[i] + b_len[i] + B_WAIT);
    end
    check_eq("a_phy", 32'(phy_a), 32'(ep_a));
    check_eq("a_rdy", 32'(rdy_a), 32'(er_a));
    check_eq("a_busy", 32'(busy_a), 32'(~&er_a));
    check_eq("b_phy", 32'(phy_b), 32'(ep_b));
    check_eq("b_rdy", 32'(rdy_b), 32'(er_b));
    check_eq("b_busy", 32'(busy_b), 32'(~&er_b));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_phy_a"}, 32'(phy_a), 32'(0));
    check_eq({tag, "_rdy_a"}, 32'(rdy_a), 32'(0));
    check_eq({tag, "_busy_a"}, 32'(busy_a), 32'(1));
    check_eq({tag, "_phy_b"}, 32'(phy_b), 32'(0));
    check_eq({tag, "_rdy_b"}, 32'(rdy_b), 32'(0));
    check_eq({tag, "_busy_b"}, 32'(busy_b), 32'(1));
  endtask

  // One clock: drive requests, let the edge happen, update the model, compare.
  task automatic step(input logic [A_CH-1:0] ra, input logic [B_CH-1:0] rb);
    req_a = ra;
    req_b = rb;
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < A_CH; i++) if (ra[i]) begin a_start[i] = edge_n; a_len[i] = A_ASSERT; end
    for (int i = 0; i < B_CH; i++) if (rb[i]) begin b_start[i] = edge_n; b_len[i] = B_ASSERT; end
    if (ra != '0 || rb != '0) $display("req edge=%0d a=%b b=%b", edge_n, ra, rb);
    #1;
    check_model();
  endtask

  // Async reset pulse issued mid-cycle; outputs must clear before any clock edge.
  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    check_reset_vals("async");
    @(posedge clk);
    #1;
    check_reset_vals("hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    $display("reset pulse done, power-on restarts");
  endtask

  initial begin
    logic [A_CH-1:0] ra;
    logic [B_CH-1:0] rb;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    // Directed: power-on, single req, repeated req in hold, parallel req, held req on B.
    for (int e = 1; e <= 60; e++) begin
      ra = '0;
      rb = '0;
      if (e == 20 || e == 22) ra = 2'b01;
      if (e == 40) ra = 2'b11;
      if (e >= 30 && e <= 32) rb = 3'b101;
      step(ra, rb);
      if (e == 4)  check_eq("a_phy0_e4", 32'(phy_a[0]), 32'(1));
      if (e == 6)  check_eq("a_phy1_e6", 32'(phy_a[1]), 32'(0));
      if (e == 7)  check_eq("a_phy1_e7", 32'(phy_a[1]), 32'(1));
      if (e == 12) check_eq("a_busy_e12", 32'(busy_a), 32'(0));
      if (e == 1)  check_eq("b_rdy_e1", 32'(rdy_b), 32'(3'b111));
      if (e == 25) check_eq("a_phy0_e25", 32'(phy_a[0]), 32'(0));
      if (e == 31) check_eq("a_rdy0_e31", 32'(rdy_a[0]), 32'(1));
      if (e == 33) check_eq("b_phy_e33", 32'(phy_b), 32'(3'b111));
      if (e == 49) check_eq("a_rdy_e49", 32'(rdy_a), 32'(2'b11));
    end

    // Async reset at edge 6 of a fresh power-on, then full timing again.
    rst_pulse();
    for (int e = 1; e <= 6; e++) step('0, '0);
    rst_pulse();
    for (int e = 1; e <= 15; e++) step('0, '0);

    // Random requests with occasional mid-sequence resets.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < A_CH; i++) ra[i] = ($urandom_range(0, 11) == 0);
      for (int i = 0; i < B_CH; i++) rb[i] = ($urandom_range(0, 5) == 0);
      step(ra, rb);
      if ($urandom_range(0, 99) == 0) rst_pulse();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
